mac_job_scheduler: RTL
======================

Name: mac_job_scheduler

Overview:
- Sequences a matrix-vector MAC pass across NUM_PU process units that share one destination accumulator register file.
- Walks job coordinates (row, col) and issues one job per cycle to the lowest-numbered free PU with a one-cycle fetch pulse and a weight index.
- Prevents two PUs from read-modify-writing the same destination column at once.
- Reports pass completion to the top-level controller.

Parameters:
NUM_PU, 4, number of process units scheduled
I_WIDTH, 4, weight/column index width; cols <= 2**I_WIDTH
R_WIDTH, 8, row counter width

Ports:
m_clk  in  1  scheduler clock, same clock as the PU state machines
rst  in  1  asynchronous, active-low reset
start  in  1  pulse; begins a pass (sampled in IDLE only)
cfg_rows  in  R_WIDTH  input-vector length N; latched on start
cfg_cols  in  I_WIDTH+1  column count M; latched on start
fifo_empty  in  1  operand FIFO empty; no issue while high
pu_finish  in  NUM_PU  per-PU finish_enable (1 = idle or finished)
pu_fetch_en  out  NUM_PU  per-PU fetch_enable; one-cycle pulse, at most one bit high per cycle
pu_index  out  NUM_PU*I_WIDTH  per-PU weight_index; slice k = bits [k*I_WIDTH +: I_WIDTH]
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse at end of pass
issued_cnt  out  R_WIDTH+I_WIDTH+1  jobs issued in the current pass

Behaviour:
- Reset (rst low, asynchronous):
  - State = IDLE.
  - pu_fetch_en=0, pu_index=0, busy=0, done=0, issued_cnt=0.
  - Counters, busy bits and armed bits cleared.
  - Reset asserted mid-pass abandons the pass; no done pulse is produced.
- States: IDLE, ISSUE, DRAIN, DONE. All registered on m_clk.
- IDLE:
  - On start=1, latch cfg_rows/cfg_cols and clear row_cnt, col_cnt, issued_cnt.
  - If either latched value is 0, go to DONE; otherwise go to ISSUE.
  - start is ignored in every other state.
- Per-PU tracking: each PU k has a busy bit pb[k] and an armed bit ar[k].
  - Issue to k sets pb[k]=1 and ar[k]=0.
  - While pb[k]=1, pu_finish[k]=0 sets ar[k]=1.
  - While pb[k]=1 and ar[k]=1, pu_finish[k]=1 clears pb[k].
  - Effect: the PU's stale high finish in the issue cycle and the cycle after it is not taken as completion.
- ISSUE: in a cycle, a job is issued when all of the following hold:
  - fifo_empty=0.
  - Some k has pb[k]=0 and pu_finish[k]=1.
  - No PU j with pb[j]=1 holds pu_index[j]==col_cnt (column hazard hold).
- On issue:
  - Choose the lowest such k.
  - pu_fetch_en[k]=1 for exactly one cycle; pu_index slice k <= col_cnt.
  - issued_cnt +1.
  - col_cnt +1; when col_cnt==cols-1 it wraps to 0 and row_cnt +1.
- A PU's pu_index slice is held stable until that PU is issued again.
- Issue of the last job (row_cnt==rows-1, col_cnt==cols-1) moves the state to DRAIN.
- Blocked cycles (FIFO empty, no free PU, or hazard) issue nothing and hold the counters; there is no timeout.
- Throughput: at most 1 issue per cycle. Latency from start to first pu_fetch_en is 2 cycles (IDLE->ISSUE, then issue).
- DRAIN: when all pb=0, go to DONE.
- DONE: done=1 for one cycle, then IDLE. busy falls in the same cycle done rises.
- A pu_finish deassert on a PU with pb=0 is ignored; that PU is simply not selected while its pu_finish=0.
- Arithmetic:
  - Counters are unsigned.
  - issued_cnt equals rows*cols at DONE.
  - cfg_cols above 2**I_WIDTH is out of range, with no defined result.

Test Plan:
- Basic pass: rows=2, cols=4, fifo_empty=0, PU models take 6 cycles -> PUs 0,1,2,3 receive indices 0,1,2,3. Second-row jobs go to each PU as it frees. issued_cnt=8 at done. Exactly one done pulse.
- Column hazard: rows=3, cols=1, NUM_PU=4 -> every job has index 0, and only one pb is ever set at a time. The next issue comes no earlier than the cycle after the previous PU's finish rises.
- FIFO stall: fifo_empty held high for 5 cycles mid-pass -> no pu_fetch_en during the stall. col_cnt and row_cnt are unchanged, and issue resumes the cycle after fifo_empty=0.
- Zero config: start with cfg_rows=0, cols=4 -> DONE the next cycle, done pulse, no fetch pulses, issued_cnt=0.
- Reset mid-pass: rst low during ISSUE after 3 issues -> all outputs 0 immediately. A following start with rows=1, cols=2 yields issued_cnt=2 and done.
- Start while busy: start pulsed in ISSUE with different cfg -> ignored. The pass completes with the original rows*cols.

Source files
------------

// File: rtl/mac_job_scheduler_if.sv
// Control/status bundle between the pass controller, the PU array and mac_job_scheduler.
// master drives start, config and PU/FIFO status; slave (the scheduler) drives fetch, index and pass status.
interface mac_job_scheduler_if #(
    parameter int NUM_PU  = 4,
    parameter int I_WIDTH = 4,
    parameter int R_WIDTH = 8
);
    logic                          start;
    logic [R_WIDTH-1:0]            cfg_rows;
    logic [I_WIDTH:0]              cfg_cols;
    logic                          fifo_empty;
    logic [NUM_PU-1:0]             pu_finish;
    logic [NUM_PU-1:0]             pu_fetch_en;
    logic [NUM_PU*I_WIDTH-1:0]     pu_index;
    logic                          busy;
    logic                          done;
    logic [R_WIDTH+I_WIDTH:0]      issued_cnt;

    modport master (
        output start, cfg_rows, cfg_cols, fifo_empty, pu_finish,
        input  pu_fetch_en, pu_index, busy, done, issued_cnt
    );

    modport slave (
        input  start, cfg_rows, cfg_cols, fifo_empty, pu_finish,
        output pu_fetch_en, pu_index, busy, done, issued_cnt
    );
endinterface

// File: rtl/mac_job_scheduler.sv
// Walks (row, col) jobs of a MAC pass and hands one per cycle to the lowest free PU, 2 cycles start->first fetch.
// Stalls without timeout on empty operand FIFO, no free PU, or a PU still owning the same destination column.
module mac_job_scheduler #(
    parameter int NUM_PU  = 4,
    parameter int I_WIDTH = 4,
    parameter int R_WIDTH = 8
) (
    input  logic                 m_clk,
    input  logic                 rst,
    mac_job_scheduler_if.slave   bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam int CW = R_WIDTH + I_WIDTH + 1;

    logic [1:0]                state_q, state_d;
    logic [R_WIDTH-1:0]        rows_q, rows_d, row_cnt_q, row_cnt_d;
    logic [I_WIDTH:0]          cols_q, cols_d;
    logic [I_WIDTH-1:0]        col_cnt_q, col_cnt_d;
    logic [CW-1:0]             issued_q, issued_d;
    logic [NUM_PU-1:0]         pb_q, pb_d, ar_q, ar_d, fetch_q, fetch_d;
    logic [NUM_PU*I_WIDTH-1:0] idx_q, idx_d;

    logic [NUM_PU-1:0] free, grant;
    logic              found, hazard, issue, last_col, last_row;

    always_comb begin
        free   = ~pb_q & bus.pu_finish;
        grant  = '0;
        found  = 1'b0;
        hazard = 1'b0;
        for (int k = 0; k < NUM_PU; k++) begin
            if (free[k] && !found) begin
                grant[k] = 1'b1;
                found    = 1'b1;
            end
            // a PU still owning this column would race us on the accumulator
            if (pb_q[k] && (idx_q[k*I_WIDTH +: I_WIDTH] == col_cnt_q)) begin
                hazard = 1'b1;
            end
        end
    end

    assign issue    = (state_q == S_ISSUE) && !bus.fifo_empty && found && !hazard;
    assign last_col = ({1'b0, col_cnt_q} == (cols_q - (I_WIDTH+1)'(1)));
    assign last_row = (row_cnt_q == (rows_q - R_WIDTH'(1)));

    always_comb begin
        state_d   = state_q;
        rows_d    = rows_q;
        cols_d    = cols_q;
        row_cnt_d = row_cnt_q;
        col_cnt_d = col_cnt_q;
        issued_d  = issued_q;
        idx_d     = idx_q;
        fetch_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    rows_d    = bus.cfg_rows;
                    cols_d    = bus.cfg_cols;
                    row_cnt_d = '0;
                    col_cnt_d = '0;
                    issued_d  = '0;
                    state_d   = ((bus.cfg_rows == '0) || (bus.cfg_cols == '0)) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issue) begin
                    fetch_d  = grant;
                    issued_d = issued_q + CW'(1);
                    for (int k = 0; k < NUM_PU; k++) begin
                        if (grant[k]) begin
                            idx_d[k*I_WIDTH +: I_WIDTH] = col_cnt_q;
                        end
                    end
                    if (last_col) begin
                        col_cnt_d = '0;
                        row_cnt_d = row_cnt_q + R_WIDTH'(1);
                        if (last_row) begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        col_cnt_d = col_cnt_q + I_WIDTH'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (pb_q == '0) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ar gates completion: finish must be seen low once after issue before a high counts
    always_comb begin
        pb_d = pb_q;
        ar_d = ar_q;
        for (int k = 0; k < NUM_PU; k++) begin
            if (issue && grant[k]) begin
                pb_d[k] = 1'b1;
                ar_d[k] = 1'b0;
            end else if (pb_q[k]) begin
                if (!bus.pu_finish[k]) begin
                    ar_d[k] = 1'b1;
                end else if (ar_q[k]) begin
                    pb_d[k] = 1'b0;
                    ar_d[k] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge m_clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            rows_q    <= '0;
            cols_q    <= '0;
            row_cnt_q <= '0;
            col_cnt_q <= '0;
            issued_q  <= '0;
            pb_q      <= '0;
            ar_q      <= '0;
            fetch_q   <= '0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            rows_q    <= rows_d;
            cols_q    <= cols_d;
            row_cnt_q <= row_cnt_d;
            col_cnt_q <= col_cnt_d;
            issued_q  <= issued_d;
            pb_q      <= pb_d;
            ar_q      <= ar_d;
            fetch_q   <= fetch_d;
            idx_q     <= idx_d;
        end
    end

    assign bus.pu_fetch_en = fetch_q;
    assign bus.pu_index    = idx_q;
    assign bus.busy        = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign bus.done        = (state_q == S_DONE);
    assign bus.issued_cnt  = issued_q;
endmodule
